// File: rtl/dbg_channel_selector.sv
// Debug channel selector: debounced up/down/hold buttons, wrap/saturate index, auto-scan, freeze snapshot.
// Latency: raw button edge to press pulse is DEBOUNCE_CYC+3 cycles; data_out trails sel by one cycle.
module dbg_channel_selector #(
    parameter int N_CH         = 16,
    parameter int DATA_W       = 8,
    parameter int SEL_W        = 4,
    parameter int DEBOUNCE_CYC = 200000,
    parameter int SCAN_PERIOD  = 50000000,
    parameter int WRAP         = 1
) (
    input  logic                     qzt_clk,
    input  logic                     reset,
    input  logic                     btn_up,
    input  logic                     btn_down,
    input  logic                     btn_hold,
    input  logic                     scan_en,
    input  logic [N_CH*DATA_W-1:0]   ch_bus,
    output logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        data_out,
    output logic                     hold_active,
    output logic                     sel_changed
);
    localparam int DB_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int SC_W = (SCAN_PERIOD > 2) ? $clog2(SCAN_PERIOD) : 1;
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [DB_W-1:0]  DB_ONE  = DB_W'(1);
    localparam logic [SC_W-1:0]  SC_LAST = SC_W'(SCAN_PERIOD - 1);
    localparam logic [SC_W-1:0]  SC_ONE  = SC_W'(1);
    localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(N_CH - 1);
    localparam logic [SEL_W-1:0] SEL_ONE = SEL_W'(1);

    // Button vectors are ordered {hold, down, up}.
    logic [2:0]      raw;
    logic [2:0]      sync1_q, sync2_q;
    logic [2:0]      stab_q, stab_d, stab_prev_q;
    logic [2:0]      arm_q, arm_d;
    logic [2:0]      press_q;
    logic [DB_W-1:0] cnt_q [3];
    logic [DB_W-1:0] cnt_d [3];

    assign raw = {btn_hold, btn_down, btn_up};

    // Until a button has been seen released for the full debounce time it is not armed,
    // so a press already held across reset can never produce a pulse.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cnt_d[i]  = cnt_q[i];
            stab_d[i] = stab_q[i];
            arm_d[i]  = arm_q[i];
            if (!arm_q[i]) begin
                if (sync2_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == DB_LAST) begin
                    cnt_d[i] = '0;
                    arm_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + DB_ONE;
                end
            end else if (sync2_q[i] == stab_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
                cnt_d[i]  = '0;
                stab_d[i] = sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + DB_ONE;
            end
        end
    end

    // Synchronisers reset to 1 so their reset value never looks like a release.
    always_ff @(posedge qzt_clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            stab_q      <= '0;
            stab_prev_q <= '0;
            arm_q       <= '0;
            press_q     <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            stab_q      <= stab_d;
            stab_prev_q <= stab_q;
            arm_q       <= arm_d;
            press_q     <= stab_q & ~stab_prev_q;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SC_W-1:0]   tmr_q, tmr_d;
    logic              hold_q, hold_d;
    logic              chg_q, chg_d;
    logic [DATA_W-1:0] snap_q, snap_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] ch_word;
    logic              up, dn, hd;

    assign up      = press_q[0];
    assign dn      = press_q[1];
    assign hd      = press_q[2];
    assign ch_word = ch_bus[int'(sel_q)*DATA_W +: DATA_W];

    always_comb begin
        sel_d  = sel_q;
        tmr_d  = tmr_q;
        hold_d = hold_q ^ hd;
        snap_d = (hd && !hold_q) ? ch_word : snap_q;
        data_d = hold_q ? snap_q : ch_word;
        if (hold_q) begin
            tmr_d = tmr_q;
        end else if (up || dn) begin
            tmr_d = '0;
            if (up && !dn) begin
                if (sel_q == CH_LAST) sel_d = (WRAP != 0) ? '0 : CH_LAST;
                else                  sel_d = sel_q + SEL_ONE;
            end else if (dn && !up) begin
                if (sel_q == '0) sel_d = (WRAP != 0) ? CH_LAST : '0;
                else             sel_d = sel_q - SEL_ONE;
            end
        end else if (scan_en) begin
            if (tmr_q == SC_LAST) begin
                tmr_d = '0;
                sel_d = (sel_q == CH_LAST) ? '0 : sel_q + SEL_ONE;
            end else begin
                tmr_d = tmr_q + SC_ONE;
            end
        end else begin
            tmr_d = '0;
        end
        chg_d = (sel_d != sel_q);
    end

    always_ff @(posedge qzt_clk or posedge reset) begin
        if (reset) begin
            sel_q  <= '0;
            tmr_q  <= '0;
            hold_q <= 1'b0;
            chg_q  <= 1'b0;
            snap_q <= '0;
            data_q <= '0;
        end else begin
            sel_q  <= sel_d;
            tmr_q  <= tmr_d;
            hold_q <= hold_d;
            chg_q  <= chg_d;
            snap_q <= snap_d;
            data_q <= data_d;
        end
    end

    assign sel         = sel_q;
    assign data_out    = data_q;
    assign hold_active = hold_q;
    assign sel_changed = chg_q;
endmodule

// File: tb/tb_dbg_channel_selector.sv
// Randomised bench for dbg_channel_selector: a wrapping and a saturating instance share stimulus,
// a reference model queues the expected outputs per clock and a monitor pops and compares them.
module tb_dbg_channel_selector;
    localparam int N     = 12;
    localparam int DW    = 8;
    localparam int DEB   = 4;
    localparam int SCAN  = 10;
    localparam int NCYC  = 8000;

    typedef struct {
        int s0, s1, d0, d1, h, c0, c1;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            b_up, b_dn, b_hd, scan_en;
    logic [N*DW-1:0] ch_bus;
    logic [3:0]      sel_a, sel_b;
    logic [DW-1:0]   data_a, data_b;
    logic            hold_a, hold_b, chg_a, chg_b;

    always #5 clk = ~clk;

    dbg_channel_selector #(.N_CH(N), .DATA_W(DW), .SEL_W(4), .DEBOUNCE_CYC(DEB),
                           .SCAN_PERIOD(SCAN), .WRAP(1)) u_wrap (
        .qzt_clk(clk), .reset(rst), .btn_up(b_up), .btn_down(b_dn), .btn_hold(b_hd),
        .scan_en(scan_en), .ch_bus(ch_bus), .sel(sel_a), .data_out(data_a),
        .hold_active(hold_a), .sel_changed(chg_a));

    dbg_channel_selector #(.N_CH(N), .DATA_W(DW), .SEL_W(4), .DEBOUNCE_CYC(DEB),
                           .SCAN_PERIOD(SCAN), .WRAP(0)) u_sat (
        .qzt_clk(clk), .reset(rst), .btn_up(b_up), .btn_down(b_dn), .btn_hold(b_hd),
        .scan_en(scan_en), .ch_bus(ch_bus), .sel(sel_b), .data_out(data_b),
        .hold_active(hold_b), .sel_changed(chg_b));

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t exp_q[$];

    // Press events: fire[b][c] means button b's press is acted on at clock edge c.
    bit          fire [3][NCYC+16];
    int          ph_left [3];
    bit          lvl [3];
    int          scan_left;
    int          m_sel [2];
    logic [7:0]  m_snap [2];
    int          m_tmr;
    bit          m_hold;
    int          rst_cnt, pend_rst, n_rst, k_ch;
    const int    WRP [2] = '{1, 0};

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_zero(input string when);
        chk({when, "_sel_wrap"},  int'(sel_a), 0);
        chk({when, "_sel_sat"},   int'(sel_b), 0);
        chk({when, "_data_wrap"}, int'(data_a), 0);
        chk({when, "_data_sat"},  int'(data_b), 0);
        chk({when, "_hold_wrap"}, int'(hold_a), 0);
        chk({when, "_hold_sat"},  int'(hold_b), 0);
        chk({when, "_chg_wrap"},  int'(chg_a), 0);
        chk({when, "_chg_sat"},   int'(chg_b), 0);
    endtask

    // A button alternates low gaps (long enough to re-settle) with either a short glitch,
    // which must be filtered, or a real press, whose effect is scheduled DEB+3 edges later.
    task automatic sched(input int b);
        if (ph_left[b] == 0) begin
            if (lvl[b]) begin
                lvl[b]     = 1'b0;
                ph_left[b] = DEB + 2 + ((b == 2) ? 60 + int'($urandom_range(0, 150))
                                                 : int'($urandom_range(0, 30)));
            end else begin
                lvl[b] = 1'b1;
                if ($urandom_range(0, 3) == 0) begin
                    ph_left[b] = int'($urandom_range(1, DEB - 1));
                end else begin
                    ph_left[b] = DEB + int'($urandom_range(0, 6));
                    fire[b][cyc + DEB + 3] = 1'b1;
                end
            end
        end
        ph_left[b]--;
    endtask

    task automatic model_reset();
        m_sel  = '{0, 0};
        m_snap = '{8'h00, 8'h00};
        m_tmr  = 0;
        m_hold = 1'b0;
    endtask

    task automatic model_step();
        exp_t       e;
        bit         up, dn, hd;
        int         nsel [2];
        int         dat [2];
        bit         chg [2];
        logic [7:0] w;
        up = fire[0][cyc];
        dn = fire[1][cyc];
        hd = fire[2][cyc];
        for (int d = 0; d < 2; d++) begin
            w      = ch_bus[m_sel[d]*DW +: DW];
            dat[d] = m_hold ? int'(m_snap[d]) : int'(w);
            nsel[d] = m_sel[d];
            if (!m_hold) begin
                if (up && !dn)
                    nsel[d] = WRP[d] ? (m_sel[d] + 1) % N : ((m_sel[d] == N - 1) ? N - 1 : m_sel[d] + 1);
                else if (dn && !up)
                    nsel[d] = WRP[d] ? (m_sel[d] + N - 1) % N : ((m_sel[d] == 0) ? 0 : m_sel[d] - 1);
                else if (!up && !dn && scan_en && m_tmr == SCAN - 1)
                    nsel[d] = (m_sel[d] + 1) % N;
            end
            if (hd && !m_hold) m_snap[d] = w;
            chg[d]   = (nsel[d] != m_sel[d]);
            m_sel[d] = nsel[d];
        end
        if (!m_hold) begin
            if (up || dn)                               m_tmr = 0;
            else if (scan_en && m_tmr < SCAN - 1)       m_tmr = m_tmr + 1;
            else                                        m_tmr = 0;
        end
        m_hold = m_hold ^ hd;
        e.s0 = m_sel[0]; e.s1 = m_sel[1];
        e.d0 = dat[0];   e.d1 = dat[1];
        e.h  = int'(m_hold);
        e.c0 = int'(chg[0]); e.c1 = int'(chg[1]);
        exp_q.push_back(e);
    endtask

    // Asynchronous reset mid-cycle while up is being held: outputs must clear at once.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1 chk_zero("async_reset");
        rst_cnt = 3;
        model_reset();
        for (int b = 0; b < 3; b++)
            for (int c = cyc; c < NCYC + 16; c++) fire[b][c] = 1'b0;
        lvl[0] = 1'b1; ph_left[0] = 12;
        lvl[1] = 1'b0; ph_left[1] = 30;
        lvl[2] = 1'b0; ph_left[2] = 30;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sel_wrap",  int'(sel_a),  e.s0);
                chk("sel_sat",   int'(sel_b),  e.s1);
                chk("data_wrap", int'(data_a), e.d0);
                chk("data_sat",  int'(data_b), e.d1);
                chk("hold_wrap", int'(hold_a), e.h);
                chk("hold_sat",  int'(hold_b), e.h);
                chk("chg_wrap",  int'(chg_a),  e.c0);
                chk("chg_sat",   int'(chg_b),  e.c1);
            end
        end
    end

    initial begin : driver
        rst = 1'b1; b_up = 1'b0; b_dn = 1'b0; b_hd = 1'b0; scan_en = 1'b0;
        for (int k = 0; k < N; k++) ch_bus[k*DW +: DW] = 8'(8'hA0 + k);
        #1 chk_zero("reset_state");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int b = 0; b < 3; b++) begin
            lvl[b]     = 1'b0;
            ph_left[b] = DEB + 10 + b;
        end
        scan_left = 20;
        rst_cnt   = 0;
        pend_rst  = 0;
        n_rst     = 0;
        for (cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (rst_cnt > 0) begin
                rst_cnt--;
                if (rst_cnt == 0) rst = 1'b0;
            end
            if (pend_rst == 0 && rst_cnt == 0 &&
                ((n_rst == 0 && ((cyc >= 2500 && m_hold) || cyc >= 3500)) ||
                 (n_rst == 1 && cyc >= 6000))) begin
                pend_rst   = 3;
                lvl[0]     = 1'b1;
                ph_left[0] = 1000;
            end
            if (pend_rst > 0) begin
                pend_rst--;
                if (pend_rst == 0) begin
                    do_reset();
                    n_rst++;
                end
            end
            for (int b = 0; b < 3; b++) sched(b);
            if (scan_left == 0) begin
                scan_en   = ($urandom_range(0, 2) != 0);
                scan_left = int'($urandom_range(5, 80));
            end
            scan_left--;
            if ($urandom_range(0, 7) == 0) begin
                k_ch = int'($urandom_range(0, N - 1));
                ch_bus[k_ch*DW +: DW] = 8'($urandom);
            end
            b_up = lvl[0];
            b_dn = lvl[1];
            b_hd = lvl[2];
            if (rst) begin
                exp_q.push_back('{0, 0, 0, 0, 0, 0, 0});
            end else begin
                model_step();
            end
        end
        @(posedge clk);
        #2 chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
